// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg
// Shared definitions for the bit-serial add/subtract engine:
//   - state_t      : controller states (IDLE / RUN / DONE)
//   - OP_ADD/OP_SUB: encoding of the op select input
//   - cnt_width()  : bit-counter width for a given operand width
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Counter only needs to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_bit_cell.sv
// addsub_bit_cell
// Combinational 1-bit full adder / full subtractor built from two
// half add/sub stages.
// Ports:
//   a, b  : operand bits
//   cin   : carry-in (add) or borrow-in (sub)
//   op    : OP_ADD or OP_SUB
//   s     : sum / difference bit
//   cout  : carry-out (add) or borrow-out (sub)
module addsub_bit_cell
    import serial_addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic op,
    output logic s,
    output logic cout
);

    // Half add/sub: returns {carry_or_borrow, sum_or_diff}.
    // The only difference between the two is inverting the minuend
    // before the AND (borrow = ~x & y, carry = x & y).
    function automatic logic [1:0] half_stage(input logic x, input logic y, input logic o);
        return {(((o == OP_SUB) ? ~x : x) & y), (x ^ y)};
    endfunction

    logic [1:0] h1;
    logic [1:0] h2;

    always_comb begin
        h1   = half_stage(a, b, op);
        h2   = half_stage(h1[0], cin, op);
        s    = h2[0];
        cout = h1[1] | h2[1];
    end

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub
// Bit-serial add/subtract engine. Operands are accepted over a valid/ready
// handshake, processed one bit per cycle LSB first through a single
// addsub_bit_cell with a registered carry/borrow, and the result is
// returned over a second valid/ready handshake.
// Parameters:
//   WIDTH     : operand/result width, 2..64
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid  / in_ready  : operand handshake (a, b, op)
//   out_valid / out_ready : result handshake (result, cout)
//   cout      : carry-out for add, borrow-out (A < B) for subtract
//   busy      : high while computing or holding a result
// Optional build macro:
//   SERIAL_ADDSUB_OVF_EN adds output ovf: two's-complement signed overflow.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             op_q, op_d;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic cell_s;
    logic cell_cout;
    logic last_bit;

    addsub_bit_cell u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .op   (op_q),
        .s    (cell_s),
        .cout (cell_cout)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        op_d     = op_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    op_d    = op;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[cnt_q] = cell_s;
                a_sh_d          = a_sh_q >> 1;
                b_sh_d          = b_sh_q >> 1;
                carry_d         = cell_cout;
                if (last_bit) begin
                    // Counter is left at WIDTH-1 so it never wraps.
                    cout_d  = cell_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
                    // carry_q is the carry/borrow into the MSB here.
                    ovf_d   = carry_q ^ cell_cout;
`endif
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Operand shift registers are pure datapath; they are always loaded
    // before use, so they carry no reset.
    always_ff @(posedge clk) begin
        a_sh_q <= a_sh_d;
        b_sh_q <= b_sh_d;
        op_q   <= op_d;
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = result_q;
    assign cout      = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub
// Scoreboard bench for serial_addsub (WIDTH=8): directed and random
// transactions, expected values from an arithmetic reference model.
// Build with SERIAL_ADDSUB_OVF_EN to also cover the ovf output.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         busy;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic         ovf;
`endif

    serial_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .busy      (busy)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   have_cur = 0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   rdy_auto = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain unsigned and signed arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
        exp_t   m;
        longint ux, uy, sx, sy, r, s, lim;
        lim = longint'(1) << W;
        ux  = longint'(x);
        uy  = longint'(y);
        sx  = x[W-1] ? ux - lim : ux;
        sy  = y[W-1] ? uy - lim : uy;
        if (!o) begin
            r    = ux + uy;
            m.co = (r >= lim);
            s    = sx + sy;
        end else begin
            r    = ux - uy;
            m.co = (ux < uy);
            s    = sx - sy;
        end
        m.res = r[W-1:0];
        m.ov  = (s > (lim / 2) - 1) || (s < -(lim / 2));
        m.acc = 0;
        return m;
    endfunction

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic o, input bit push);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("in_ready_timeout", 64'd0, 64'd1);
            return;
        end
        a        = x;
        b        = y;
        op       = o;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble operands: changes after acceptance must not matter.
        a  = W'($urandom);
        b  = W'($urandom);
        op = 1'($urandom);
        if (push) begin
            e     = model(x, y, o);
            e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    // Random consumer back-pressure.
    always @(posedge clk) begin
        #2;
        if (rdy_auto) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops one expectation per result and checks it stays stable.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (!have_cur) begin
                    if (sb.size() == 0) begin
                        chk("spurious_out_valid", 64'd1, 64'd0);
                    end else begin
                        cur      = sb.pop_front();
                        have_cur = 1;
                        chk("latency", 64'(cyc - cur.acc), 64'(W));
                        chk("result", 64'(result), 64'(cur.res));
                        chk("cout", 64'(cout), 64'(cur.co));
`ifdef SERIAL_ADDSUB_OVF_EN
                        chk("ovf", 64'(ovf), 64'(cur.ov));
`endif
                    end
                end else begin
                    chk("result_hold", 64'(result), 64'(cur.res));
                    chk("cout_hold", 64'(cout), 64'(cur.co));
                end
                chk("in_ready_done", 64'(in_ready), 64'd0);
                chk("busy_done", 64'(busy), 64'd1);
            end else begin
                have_cur = 0;
                if (!busy) chk("in_ready_idle", 64'(in_ready), 64'd1);
            end
        end
    end

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         o;
    } vec_t;

    initial begin
        vec_t dir[$];
        int   n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst      = 1'b0;
        rdy_auto = 1'b1;

        dir.push_back('{8'h5A, 8'h3C, 1'b0});
        dir.push_back('{8'hFF, 8'h01, 1'b0});
        dir.push_back('{8'h10, 8'h01, 1'b1});
        dir.push_back('{8'h00, 8'h01, 1'b1});
        dir.push_back('{8'h37, 8'h37, 1'b1});
        dir.push_back('{8'h7F, 8'h01, 1'b0});
        dir.push_back('{8'h80, 8'h01, 1'b1});
        dir.push_back('{8'h05, 8'h03, 1'b0});
        foreach (dir[i]) issue(dir[i].x, dir[i].y, dir[i].o, 1'b1);

        // Back-pressure: hold out_ready low for 5 cycles in DONE.
        issue(8'hA5, 8'h5A, 1'b0, 1'b1);
        rdy_auto  = 1'b0;
        #3;
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", 64'(out_valid), 64'd1);
        repeat (5) @(negedge clk);
        chk("bp_result", 64'(result), 64'hFF);
        chk("bp_cout", 64'(cout), 64'd0);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_hs_out_valid", 64'(out_valid), 64'd0);
        chk("bp_hs_in_ready", 64'(in_ready), 64'd1);
        chk("bp_hs_busy", 64'(busy), 64'd0);
        rdy_auto = 1'b1;

        // Reset while processing bit 3; that operation produces nothing.
        issue(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_cout", 64'(cout), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        issue(8'h01, 8'h01, 1'b0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end

        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
